// File: rtl/xmatch_block_scheduler.sv
// Frame sequencer for the window-matching datapath.
// For each block position (bx,by) it requests windows from the fetcher, waits
// MATCH_LAT cycles for the combinational matcher to settle, captures
// MinV/MinVIdx and presents one result beat under valid/ready backpressure.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, abort                    frame start pulse, synchronous abort
//   busy, frame_done                status, end-of-frame pulse
//   fetch_req/_bx/_by, fetch_ack    window request handshake
//   win_release                     matcher inputs may change after this pulse
//   match_v, match_idx              matcher result inputs
//   res_valid/_ready/_v/_idx/_bx/_by/_last   result beat stream
module xmatch_block_scheduler #(
  parameter int unsigned BLK_X     = 8,
  parameter int unsigned BLK_Y     = 8,
  parameter int unsigned MATCH_LAT = 2,
  parameter int unsigned VDEPTH    = 6,
  parameter int unsigned IDEPTH    = 10,
  parameter int unsigned CW        = (BLK_X > 1) ? $clog2(BLK_X) : 1,
  parameter int unsigned RW        = (BLK_Y > 1) ? $clog2(BLK_Y) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              frame_done,
  output logic              fetch_req,
  output logic [CW-1:0]     fetch_bx,
  output logic [RW-1:0]     fetch_by,
  input  logic              fetch_ack,
  output logic              win_release,
  input  logic [VDEPTH-1:0] match_v,
  input  logic [IDEPTH-1:0] match_idx,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [VDEPTH-1:0] res_v,
  output logic [IDEPTH-1:0] res_idx,
  output logic [CW-1:0]     res_bx,
  output logic [RW-1:0]     res_by,
  output logic              res_last
);

  localparam int unsigned LW = (MATCH_LAT > 1) ? $clog2(MATCH_LAT) : 1;
  localparam logic [CW-1:0] X_LAST   = CW'(BLK_X - 1);
  localparam logic [RW-1:0] Y_LAST   = RW'(BLK_Y - 1);
  localparam logic [LW-1:0] CNT_LAST = LW'(MATCH_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETTLE,
    S_CAPTURE,
    S_OUT,
    S_DONE
  } state_t;

  state_t            r_state, w_next_state;
  logic [CW-1:0]     r_bx, w_next_bx;
  logic [RW-1:0]     r_by, w_next_by;
  logic [LW-1:0]     r_cnt, w_next_cnt;
  logic              r_busy, r_fetch_req, r_res_valid, r_frame_done, r_win_release;
  logic [VDEPTH-1:0] r_res_v, w_next_res_v;
  logic [IDEPTH-1:0] r_res_idx, w_next_res_idx;
  logic [CW-1:0]     r_res_bx, w_next_res_bx;
  logic [RW-1:0]     r_res_by, w_next_res_by;
  logic              r_res_last, w_next_res_last;
  logic              w_win_release;
  logic              w_at_last;
  logic              w_windows_held;

  assign w_at_last      = (r_bx == X_LAST) && (r_by == Y_LAST);
  assign w_windows_held = (r_state == S_SETTLE) || (r_state == S_CAPTURE) || (r_state == S_OUT);

  // Next-state, counter and result-capture logic
  always_comb begin
    w_next_state    = r_state;
    w_next_bx       = r_bx;
    w_next_by       = r_by;
    w_next_cnt      = r_cnt;
    w_next_res_v    = r_res_v;
    w_next_res_idx  = r_res_idx;
    w_next_res_bx   = r_res_bx;
    w_next_res_by   = r_res_by;
    w_next_res_last = r_res_last;
    w_win_release   = 1'b0;
    if (abort) begin
      // Abort wins over everything; release the fetcher if it is still holding windows
      w_next_state  = S_IDLE;
      w_next_bx     = '0;
      w_next_by     = '0;
      w_next_cnt    = '0;
      w_win_release = w_windows_held;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) w_next_state = S_FETCH;
        end
        S_FETCH: begin
          if (fetch_ack) begin
            w_next_state = S_SETTLE;
            w_next_cnt   = '0;
          end
        end
        S_SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            w_next_state  = S_CAPTURE;
            w_win_release = 1'b1;
          end else begin
            w_next_cnt = r_cnt + LW'(1);
          end
        end
        S_CAPTURE: begin
          w_next_state    = S_OUT;
          w_next_res_v    = match_v;
          w_next_res_idx  = match_idx;
          w_next_res_bx   = r_bx;
          w_next_res_by   = r_by;
          w_next_res_last = w_at_last;
        end
        S_OUT: begin
          if (r_res_valid && res_ready) begin
            if (w_at_last) begin
              w_next_state = S_DONE;
              w_next_bx    = '0;
              w_next_by    = '0;
            end else begin
              w_next_state = S_FETCH;
              if (r_bx == X_LAST) begin
                w_next_bx = '0;
                w_next_by = r_by + RW'(1);
              end else begin
                w_next_bx = r_bx + CW'(1);
              end
            end
          end
        end
        S_DONE: begin
          w_next_state = S_IDLE;
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_bx          <= '0;
      r_by          <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_fetch_req   <= 1'b0;
      r_res_valid   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_win_release <= 1'b0;
      r_res_v       <= '0;
      r_res_idx     <= '0;
      r_res_bx      <= '0;
      r_res_by      <= '0;
      r_res_last    <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_bx          <= w_next_bx;
      r_by          <= w_next_by;
      r_cnt         <= w_next_cnt;
      r_busy        <= (w_next_state != S_IDLE);
      r_fetch_req   <= (w_next_state == S_FETCH);
      r_res_valid   <= (w_next_state == S_OUT);
      r_frame_done  <= (w_next_state == S_DONE);
      r_win_release <= w_win_release;
      r_res_v       <= w_next_res_v;
      r_res_idx     <= w_next_res_idx;
      r_res_bx      <= w_next_res_bx;
      r_res_by      <= w_next_res_by;
      r_res_last    <= w_next_res_last;
    end
  end

  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign fetch_req   = r_fetch_req;
  assign fetch_bx    = r_bx;
  assign fetch_by    = r_by;
  assign win_release = r_win_release;
  assign res_valid   = r_res_valid;
  assign res_v       = r_res_v;
  assign res_idx     = r_res_idx;
  assign res_bx      = r_res_bx;
  assign res_by      = r_res_by;
  assign res_last    = r_res_last;

endmodule

// File: tb/tb_xmatch_block_scheduler.sv
// Bench for xmatch_block_scheduler: a 2x2 frame instance driven by a fetcher /
// sink model with random delays and data, plus a 1x1 instance.
module tb_xmatch_block_scheduler;

  localparam int unsigned BX = 2, BY = 2, ML = 2, VD = 6, ID = 10;
  localparam int unsigned ML1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 2x2 instance
  logic          start, abort, fetch_ack, res_ready;
  logic [VD-1:0] match_v;
  logic [ID-1:0] match_idx;
  logic          busy, frame_done, fetch_req, win_release, res_valid, res_last;
  logic [0:0]    fetch_bx, fetch_by, res_bx, res_by;
  logic [VD-1:0] res_v;
  logic [ID-1:0] res_idx;

  // 1x1 instance
  logic          s_start, s_abort, s_fetch_ack, s_res_ready;
  logic [VD-1:0] s_match_v;
  logic [ID-1:0] s_match_idx;
  logic          s_busy, s_frame_done, s_fetch_req, s_win_release, s_res_valid, s_res_last;
  logic [0:0]    s_fetch_bx, s_fetch_by, s_res_bx, s_res_by;
  logic [VD-1:0] s_res_v;
  logic [ID-1:0] s_res_idx;

  xmatch_block_scheduler #(.BLK_X(BX), .BLK_Y(BY), .MATCH_LAT(ML), .VDEPTH(VD), .IDEPTH(ID)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .frame_done(frame_done),
    .fetch_req(fetch_req), .fetch_bx(fetch_bx), .fetch_by(fetch_by), .fetch_ack(fetch_ack),
    .win_release(win_release), .match_v(match_v), .match_idx(match_idx), .res_valid(res_valid),
    .res_ready(res_ready), .res_v(res_v), .res_idx(res_idx), .res_bx(res_bx), .res_by(res_by),
    .res_last(res_last));

  xmatch_block_scheduler #(.BLK_X(1), .BLK_Y(1), .MATCH_LAT(ML1), .VDEPTH(VD), .IDEPTH(ID)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .busy(s_busy), .frame_done(s_frame_done),
    .fetch_req(s_fetch_req), .fetch_bx(s_fetch_bx), .fetch_by(s_fetch_by), .fetch_ack(s_fetch_ack),
    .win_release(s_win_release), .match_v(s_match_v), .match_idx(s_match_idx), .res_valid(s_res_valid),
    .res_ready(s_res_ready), .res_v(s_res_v), .res_idx(s_res_idx), .res_bx(s_res_bx), .res_by(s_res_by),
    .res_last(s_res_last));

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;

  always @(negedge clk) if (frame_done === 1'b1) n_done++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One block of the 2x2 frame. mode 0: normal, 1: abort in SETTLE, 2: async reset in OUT
  task automatic do_block(input int xb, input int yb, input int ack_dly, input int stall,
                          input int mode, input bit mid_start,
                          input logic [VD-1:0] v, input logic [ID-1:0] ix);
    int w;
    int lat;
    int rel_at;
    bit last;
    last = (xb == int'(BX) - 1) && (yb == int'(BY) - 1);
    w = 0;
    while (fetch_req !== 1'b1 && w < 20) begin tick(); w++; end
    check_eq("req_seen", fetch_req, 1);
    check_eq("req_bx", fetch_bx, xb);
    check_eq("req_by", fetch_by, yb);
    for (int i = 0; i < ack_dly; i++) begin
      if (mid_start && i == 1) start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("req_held", fetch_req, 1);
      check_eq("req_bx_hold", fetch_bx, xb);
      check_eq("req_by_hold", fetch_by, yb);
    end
    match_v = v;
    match_idx = ix;
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    check_eq("req_drop", fetch_req, 0);
    if (mode == 1) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_req", fetch_req, 0);
      check_eq("abort_valid", res_valid, 0);
      check_eq("abort_release", win_release, 1);
      check_eq("abort_done", frame_done, 0);
      tick();
      check_eq("abort_release_end", win_release, 0);
      check_eq("abort_idle", busy, 0);
      return;
    end
    lat = 1;
    rel_at = -1;
    while (res_valid !== 1'b1 && lat < 20) begin
      if (win_release === 1'b1) rel_at = lat;
      res_ready = 1'($urandom);
      tick();
      lat++;
    end
    check_eq("latency", lat, ML + 2);
    check_eq("release_at", rel_at, ML + 1);
    if (mode == 2) begin
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_valid", res_valid, 0);
      check_eq("rst_v", res_v, 0);
      check_eq("rst_idx", res_idx, 0);
      check_eq("rst_misc", {fetch_req, win_release, frame_done, res_last, res_bx, res_by, fetch_bx, fetch_by}, 0);
      tick();
      rst_n = 1'b1;
      res_ready = 1'b0;
      tick();
      check_eq("rst_idle", busy, 0);
      return;
    end
    res_ready = 1'b0;
    match_v = VD'($urandom);
    match_idx = ID'($urandom);
    for (int s = 0; s < stall; s++) begin
      tick();
      check_eq("stall_valid", res_valid, 1);
      check_eq("stall_v", res_v, v);
      check_eq("stall_idx", res_idx, ix);
      check_eq("stall_noreq", fetch_req, 0);
    end
    check_eq("beat_v", res_v, v);
    check_eq("beat_idx", res_idx, ix);
    check_eq("beat_bx", res_bx, xb);
    check_eq("beat_by", res_by, yb);
    check_eq("beat_last", res_last, last);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq("post_valid", res_valid, 0);
    if (last) begin
      check_eq("done_pulse", frame_done, 1);
      check_eq("done_busy", busy, 1);
      tick();
      check_eq("done_end", frame_done, 0);
      check_eq("done_idle", busy, 0);
    end else begin
      check_eq("next_req", fetch_req, 1);
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic random_frame();
    start_frame();
    for (int k = 0; k < int'(BX * BY); k++)
      do_block(k % int'(BX), k / int'(BX), $urandom_range(0, 3), $urandom_range(0, 3), 0, 1'b0,
               VD'($urandom), ID'($urandom));
  endtask

  initial begin
    int w;
    int lat;
    start = 0; abort = 0; fetch_ack = 0; res_ready = 0; match_v = '0; match_idx = '0;
    s_start = 0; s_abort = 0; s_fetch_ack = 0; s_res_ready = 0; s_match_v = '0; s_match_idx = '0;
    repeat (3) tick();
    check_eq("reset_busy", busy, 0);
    check_eq("reset_outs", {fetch_req, res_valid, frame_done, win_release, res_last, fetch_bx, fetch_by}, 0);
    check_eq("reset_res", {res_v, res_idx, res_bx, res_by}, 0);
    check_eq("reset1_outs", {s_busy, s_fetch_req, s_res_valid, s_frame_done, s_res_last}, 0);
    rst_n = 1'b1;
    tick();

    // Stray handshakes in IDLE, and abort beating start
    fetch_ack = 1'b1; res_ready = 1'b1;
    tick();
    fetch_ack = 1'b0; res_ready = 1'b0;
    check_eq("idle_ack_ignored", {busy, res_valid, fetch_req}, 0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_eq("abort_beats_start", {busy, fetch_req}, 0);

    // Nominal frame, ack one cycle after req, sink always ready
    start_frame();
    for (int k = 0; k < 4; k++)
      do_block(k % 2, k / 2, 1, 0, 0, 1'b0,
               (k == 0) ? 6'h15 : VD'($urandom), (k == 0) ? 10'h07B : ID'($urandom));
    tick();
    check_eq("done_count_1", n_done, 1);

    // Long stall, mid-frame start, long ack delay
    start_frame();
    do_block(0, 0, 2, 5, 0, 1'b0, VD'($urandom), ID'($urandom));
    do_block(1, 0, 10, 1, 0, 1'b1, VD'($urandom), ID'($urandom));
    do_block(0, 1, 0, 2, 0, 1'b0, VD'($urandom), ID'($urandom));
    do_block(1, 1, 3, 0, 0, 1'b0, VD'($urandom), ID'($urandom));
    tick();
    check_eq("done_count_2", n_done, 2);

    // Abort in SETTLE of block (1,0), then a fresh frame from (0,0)
    start_frame();
    do_block(0, 0, 1, 1, 0, 1'b0, VD'($urandom), ID'($urandom));
    do_block(1, 0, 0, 0, 1, 1'b0, VD'($urandom), ID'($urandom));
    tick();
    check_eq("done_count_abort", n_done, 2);
    random_frame();
    tick();
    check_eq("done_count_3", n_done, 3);

    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 3)) tick();
      random_frame();
    end
    tick();
    check_eq("done_count_rand", n_done, 9);

    // Async reset while a beat is pending, then a clean frame
    start_frame();
    do_block(0, 0, 1, 0, 2, 1'b0, VD'($urandom), ID'($urandom));
    random_frame();
    tick();
    check_eq("done_count_rst", n_done, 10);

    // Single-block frame
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    w = 0;
    while (s_fetch_req !== 1'b1 && w < 20) begin tick(); w++; end
    check_eq("s_req", s_fetch_req, 1);
    check_eq("s_req_pos", {s_fetch_bx, s_fetch_by}, 0);
    repeat ($urandom_range(0, 4)) tick();
    s_match_v = 6'h2A; s_match_idx = 10'h3C5; s_fetch_ack = 1'b1;
    tick();
    s_fetch_ack = 1'b0;
    lat = 1;
    while (s_res_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
    check_eq("s_latency", lat, ML1 + 2);
    check_eq("s_last", s_res_last, 1);
    check_eq("s_v", s_res_v, 6'h2A);
    check_eq("s_idx", s_res_idx, 10'h3C5);
    check_eq("s_pos", {s_res_bx, s_res_by}, 0);
    s_res_ready = 1'b1;
    tick();
    s_res_ready = 1'b0;
    check_eq("s_done", s_frame_done, 1);
    tick();
    check_eq("s_idle", {s_busy, s_frame_done, s_res_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
